fetch_unit: RTL and testbench

- Instruction fetch stage of the lx32 RV32I core, directly upstream of decode/control_unit.
- Holds the fetch PC, issues word requests to instruction memory over a valid/ready request channel, and accepts in-order responses.
- Buffers fetched {pc, instr} pairs in a small FIFO and presents them to decode with a valid/ready handshake; decode slices opcode/funct3/funct7_5 from if_instr.
- Supports branch/jump redirect with flush and discard of stale in-flight responses.

---
 rtl/fetch_unit.sv | 199 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit : lx32 RV32I fetch stage - credit-gated imem requests, in-     |
// |              order responses into a DEPTH-entry FIFO toward decode, and   |
// |              redirect with discard of stale in-flight responses.          |
// | Optional   : LX32_FETCH_PERF_EN adds perf_bubble_cnt (decode starvation). |
// | Revision   : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef LX32_FETCH_PERF_EN
  ,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [IW-1:0] LAST  = IW'(DEPTH - 1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [31:0]     fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [IW-1:0]   pcq_wr;
  logic [IW-1:0]   pcq_rd;
  logic [IW-1:0]   fifo_wr;
  logic [IW-1:0]   fifo_rd;
  logic [31:0]     pcq       [DEPTH];
  logic [31:0]     fifo_pc   [DEPTH];
  logic [31:0]     fifo_ins  [DEPTH];

  logic            credit_ok;
  logic            req_fire;
  logic            rsp_any;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            pop;
  logic [CW-1:0]   redirect_drop;
  logic            unused_redirect_lsb;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign credit_ok      = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W;
  assign imem_req_valid = rst_n && (state == RUN) && credit_ok && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_any  = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep = rsp_any && (state == RUN) && !redirect_valid;
  assign rsp_drop = rsp_any && (state == FLUSH) && !redirect_valid;

  assign if_valid = (fifo_count != '0);
  assign if_instr = fifo_ins[fifo_rd];
  assign if_pc    = fifo_pc[fifo_rd];
  assign pop      = if_valid && if_ready && !redirect_valid;

  // A response landing in the redirect cycle is already accounted for, so it
  // is not counted among the stale ones still to come back.
  assign redirect_drop = rsp_any ? (outstanding - 1'b1) : outstanding;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = (redirect_drop != '0) ? FLUSH : RUN;
    end else if (rsp_drop && (drop_cnt <= CW'(1))) begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= {redirect_pc[31:2], 2'b00};
      outstanding <= redirect_drop;
      drop_cnt    <= redirect_drop;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (req_fire && !rsp_any) begin
        outstanding <= outstanding + 1'b1;
      end else if (!req_fire && rsp_any) begin
        outstanding <= outstanding - 1'b1;
      end
      if (rsp_drop && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // PC queue: address of every accepted request, retired by kept responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcq_wr <= '0;
      pcq_rd <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pcq[i] <= RESET_PC;
      end
    end else if (redirect_valid) begin
      pcq_wr <= '0;
      pcq_rd <= '0;
    end else begin
      if (req_fire) begin
        pcq[pcq_wr] <= fetch_pc;
        pcq_wr      <= ptr_inc(pcq_wr);
      end
      if (rsp_keep) begin
        pcq_rd <= ptr_inc(pcq_rd);
      end
    end
  end

  // Entries reset to {RESET_PC, NOP} so an idle head presents a harmless NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]  <= RESET_PC;
        fifo_ins[i] <= NOP;
      end
    end else if (redirect_valid) begin
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
    end else begin
      if (rsp_keep) begin
        fifo_pc[fifo_wr]  <= pcq[pcq_rd];
        fifo_ins[fifo_wr] <= imem_rsp_data;
        fifo_wr           <= ptr_inc(fifo_wr);
      end
      if (pop) begin
        fifo_rd <= ptr_inc(fifo_rd);
      end
      if (rsp_keep && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (!rsp_keep && pop) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

`ifdef LX32_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_cnt <= '0;
    end else if (if_ready && !if_valid && (perf_bubble_cnt != 32'hFFFF_FFFF)) begin
      perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

  a_rsp_protocol : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> ((outstanding != '0) &&
                        ((state == FLUSH) || redirect_valid || (fifo_count < CW'(DEPTH)))));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_unit : directed bench for fetch_unit with a simple in-order      |
// |                 instruction memory model and a recording decode sink.     |
// | Revision      : 1.0 - initial release                                     |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef LX32_FETCH_PERF_EN
  logic [31:0] perf_bubble_cnt;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic        rsp_en;
  logic [31:0] pend[$];
  logic [31:0] issued[$];
  logic [31:0] rcv_pc[$];
  logic [31:0] rcv_ins[$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
`ifdef LX32_FETCH_PERF_EN
    ,
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0033;
      32'h4:   return 32'h4000_0033;
      32'h8:   return 32'h0000_2003;
      default: return a | 32'h0000_0013;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_rsp();
    if (rsp_en && pend.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic tick();
    logic        f;
    logic        r;
    logic        p;
    logic [31:0] a;
    logic [31:0] ppc;
    logic [31:0] pin;
    @(negedge clk);
    f   = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    r   = imem_rsp_valid;
    p   = if_valid && if_ready && !redirect_valid && rst_n;
    ppc = if_pc;
    pin = if_instr;
    @(posedge clk);
    #1;
    if (r && pend.size() > 0) pend.delete(0);
    if (f) begin
      pend.push_back(a);
      issued.push_back(a);
    end
    if (p) begin
      rcv_pc.push_back(ppc);
      rcv_ins.push_back(pin);
    end
    drive_rsp();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    issued.delete();
    rcv_pc.delete();
    rcv_ins.delete();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    rsp_en         = 1'b1;
    pend.delete();
    clear_logs();
    drive_rsp();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    rsp_en         = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_if_valid",  32'(if_valid),       32'h0);
    chk("rst_if_instr",  if_instr,            32'h0000_0013);
    chk("rst_if_pc",     if_pc,               32'h0);
    chk("rst_req_addr",  imem_req_addr,       32'h0);

    // Streaming: always ready, 1-cycle latency, decode always ready
    do_reset();
    ticks(8);
    chk("s_issue0", issued[0], 32'h0);
    chk("s_issue1", issued[1], 32'h4);
    chk("s_issue2", issued[2], 32'h8);
    chk("s_pc0",    rcv_pc[0],  32'h0);
    chk("s_ins0",   rcv_ins[0], 32'h0000_0033);
    chk("s_pc1",    rcv_pc[1],  32'h4);
    chk("s_ins1",   rcv_ins[1], 32'h4000_0033);
    chk("s_pc2",    rcv_pc[2],  32'h8);
    chk("s_ins2",   rcv_ins[2], 32'h0000_2003);

    // Decode back-pressure for 10 cycles
    if_ready = 1'b0;
    do_reset();
    ticks(10);
    chk("bp_issued",    32'(issued.size()),   32'd2);
    chk("bp_req_valid", 32'(imem_req_valid),  32'h0);
    chk("bp_if_valid",  32'(if_valid),        32'h1);
    chk("bp_head_pc",   if_pc,                32'h0);
    chk("bp_head_ins",  if_instr,             32'h0000_0033);
    chk("bp_none_rcv",  32'(rcv_pc.size()),   32'd0);
    if_ready = 1'b1;
    ticks(6);
    chk("bp_pc0",    rcv_pc[0], 32'h0);
    chk("bp_pc1",    rcv_pc[1], 32'h4);
    chk("bp_pc2",    rcv_pc[2], 32'h8);
    chk("bp_issue2", issued[2], 32'h8);

    // Memory not ready for 5 cycles
    imem_req_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("nr_addr",  imem_req_addr,        32'h0);
      chk("nr_valid", 32'(imem_req_valid),  32'h1);
    end
    chk("nr_no_fire", 32'(issued.size()), 32'd0);
    imem_req_ready = 1'b1;
    ticks(3);
    chk("nr_issue0", issued[0], 32'h0);
    chk("nr_issue1", issued[1], 32'h4);

    // Redirect with two responses in flight
    do_reset();
    rsp_en = 1'b0;
    ticks(2);
    chk("rd_out2",       32'(issued.size()),  32'd2);
    chk("rd_pre_valid",  32'(imem_req_valid), 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    clear_logs();
    rsp_en = 1'b1;
    drive_rsp();
    #1;
    chk("rd_flush_req0", 32'(imem_req_valid), 32'h0);
    chk("rd_flush_ifv",  32'(if_valid),       32'h0);
    tick();
    chk("rd_flush_req1", 32'(imem_req_valid), 32'h0);
    chk("rd_flush_ifv1", 32'(if_valid),       32'h0);
    tick();
    chk("rd_run_valid", 32'(imem_req_valid), 32'h1);
    chk("rd_run_addr",  imem_req_addr,       32'h0000_0200);
    ticks(4);
    chk("rd_issue0", issued[0],  32'h0000_0200);
    chk("rd_pc0",    rcv_pc[0],  32'h0000_0200);
    chk("rd_ins0",   rcv_ins[0], 32'h0000_0213);

    // Redirect to a misaligned target mid-stream
    do_reset();
    ticks(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    clear_logs();
    tick();
    redirect_valid = 1'b0;
    ticks(8);
    chk("ma_issue0", issued[0],  32'h0000_0100);
    chk("ma_pc0",    rcv_pc[0],  32'h0000_0100);
    chk("ma_ins0",   rcv_ins[0], 32'h0000_0113);

    // Asynchronous reset mid-stream
    do_reset();
    ticks(3);
    chk("ar_pre_ifv", 32'(if_valid), 32'h1);
    chk("ar_pre_pc",  if_pc,         32'h4);
    rst_n = 1'b0;
    pend.delete();
    clear_logs();
    drive_rsp();
    #1;
    chk("ar_ifv",     32'(if_valid),       32'h0);
    chk("ar_req_val", 32'(imem_req_valid), 32'h0);
    chk("ar_if_pc",   if_pc,               32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    ticks(3);
    chk("ar_issue0", issued[0], 32'h0);
    chk("ar_pc0",    rcv_pc[0], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
